// File: rtl/lsu_pkg.sv
// Shared types and defaults for the store-buffered load/store unit.
package lsu_pkg;
  localparam int DATA_W         = 32;
  localparam int MAX_ADDR_W     = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_MAX_STARVE = 8;

  // Entry addresses are held at full width; narrower ADDR_W zero-extends on push.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } store_entry_t;
endpackage

// File: rtl/store_buffer_lsu_fifo.sv
// Store FIFO: entry storage plus head/tail pointers, occupancy, full/empty.
// STORE_FORWARD_EN exposes the raw entries so the top can forward from them.
import lsu_pkg::*;

module store_fifo #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  store_entry_t              wentry,
  output store_entry_t              head_entry,
`ifdef STORE_FORWARD_EN
  output store_entry_t [DEPTH-1:0]  entries,
  output logic [IDX_W-1:0]          head_idx,
  output logic [IDX_W:0]            count,
`endif
  output logic                      full,
  output logic                      empty
);
  logic [IDX_W:0]           head_ptr, tail_ptr, occ;
  store_entry_t [DEPTH-1:0] mem;

  // Extra pointer bit distinguishes full from empty; occupancy is their difference.
  assign occ        = tail_ptr - head_ptr;
  assign full       = (occ == (IDX_W+1)'(DEPTH));
  assign empty      = (occ == '0);
  assign head_entry = mem[head_ptr[IDX_W-1:0]];

`ifdef STORE_FORWARD_EN
  assign entries  = mem;
  assign head_idx = head_ptr[IDX_W-1:0];
  assign count    = occ;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr[IDX_W-1:0]] <= wentry;
  end
endmodule

// File: rtl/store_buffer_lsu.sv
// Load/store unit with a store buffer in front of word-addressed data memory.
// STORE_FORWARD_EN: loads forward from pending stores instead of waiting for drain.
import lsu_pkg::*;

module store_buffer_lsu #(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int ADDR_W     = MAX_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              buf_empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int ST_W  = $clog2(MAX_STARVE + 1);

  logic              full, empty;
  logic              forced, load_ok, load_acc, store_ok, store_acc, drain;
  logic [ST_W-1:0]   starve_cnt;
  store_entry_t      push_entry, head_entry;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

`ifdef STORE_FORWARD_EN
  store_entry_t [DEPTH-1:0] entries;
  logic [IDX_W-1:0]         head_idx;
  logic [IDX_W:0]           count;
`endif

  assign push_entry.addr = MAX_ADDR_W'(req_addr);
  assign push_entry.data = req_wdata;

  store_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (store_acc),
    .pop        (drain),
    .wentry     (push_entry),
    .head_entry (head_entry),
`ifdef STORE_FORWARD_EN
    .entries    (entries),
    .head_idx   (head_idx),
    .count      (count),
`endif
    .full       (full),
    .empty      (empty)
  );

  assign forced = !empty && (starve_cnt >= ST_W'(MAX_STARVE));

`ifdef STORE_FORWARD_EN
  assign load_ok = !forced;
`else
  // Without forwarding a load must see memory after every older store lands.
  assign load_ok = empty;
`endif

  assign load_acc  = req_valid && !req_write && load_ok;
  assign drain     = !empty && !load_acc;
  assign store_ok  = !full || drain;
  assign store_acc = req_valid && req_write && store_ok;
  assign req_ready = req_write ? store_ok : load_ok;
  assign buf_empty = empty;

`ifdef STORE_FORWARD_EN
  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + IDX_W'(k);
      if (((IDX_W+1)'(k) < count) && (entries[idx].addr == MAX_ADDR_W'(req_addr))) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_acc) begin
      mem_read = 1'b1;
      mem_addr = req_addr;
    end else if (drain) begin
      mem_write = 1'b1;
      mem_addr  = ADDR_W'(head_entry.addr);
      mem_wdata = head_entry.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (drain) begin
      starve_cnt <= '0;
    end else if (load_acc && !empty && (starve_cnt < ST_W'(MAX_STARVE))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= load_acc;
      if (load_acc) rsp_rdata <= fwd_hit ? fwd_data : mem_rdata;
    end
  end
endmodule
